// File: rtl/ps2_keyboard_seg_pkg.sv
// Shared constants for the PS/2 keyboard receiver and its hex display:
// the active-low 7-segment table {g,f,e,d,c,b,a} and frame helpers.
package ps2_keyboard_seg_pkg;

  localparam int         NIBBLES   = 16;
  localparam logic [3:0] STOP_IDX  = 4'd10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 15 first, so SEG_TABLE[n] yields the glyph for hex digit n.
  localparam logic [NIBBLES-1:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Odd parity over 8 data bits plus parity bit holds when their XOR is 1.
  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/encode_seg.sv
// Hex nibble to active-low 7-segment decoder with blanking enable.
module encode_seg
  import ps2_keyboard_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (en) seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/ps2_keyboard_seg.sv
// PS/2 keyboard receiver: synchronizes the device clock/data, assembles
// 11-bit frames, checks them and shows the last good byte on two hex digits.
module ps2_keyboard_seg
  import ps2_keyboard_seg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       seg_en,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [8:0]             shift_q, shift_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [7:0]             code_q, code_d;
  logic                   code_valid_q, code_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   fall, din, tmo_hit;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    fall         = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    din          = dat_sync_q[SYNC_STAGES-1];
    tmo_hit      = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is line noise, not a frame: stay idle silently.
        if (!din) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q == STOP_IDX) begin
        bit_cnt_d = 4'd0;
        if (din && parity_ok(shift_q)) begin
          code_d       = shift_q[7:0];
          code_valid_d = 1'b1;
        end else begin
          frame_err_d  = 1'b1;
        end
      end else begin
        // Data bits arrive LSB first; parity ends up in shift_q[8].
        shift_d   = {din, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_hit) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = 4'd0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

  encode_seg u_seg_lo (.nibble(code_q[3:0]), .en(seg_en), .seg(seg_lo));
  encode_seg u_seg_hi (.nibble(code_q[7:4]), .en(seg_en), .seg(seg_hi));

endmodule

// File: tb/tb_ps2_keyboard_seg.sv
// Directed bench for ps2_keyboard_seg: bit-banged PS/2 frames, checks on
// code, pulse counts and segment patterns.
module tb_ps2_keyboard_seg;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       seg_en = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;

  int vectors = 0;
  int miscompares = 0;
  int cv_total = 0;
  int fe_total = 0;
  int both_total = 0;

  ps2_keyboard_seg #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .seg_en(seg_en), .code(code), .code_valid(code_valid),
    .frame_err(frame_err), .seg_lo(seg_lo), .seg_hi(seg_hi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_total <= cv_total + 1;
    if (frame_err) fe_total <= fe_total + 1;
    if (code_valid && frame_err) both_total <= both_total + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cycles(10);
    ps2_clk = 1'b0;
    wait_cycles(20);
    ps2_clk = 1'b1;
    wait_cycles(10);
  endtask

  task automatic send_bits(input logic [7:0] data, input logic parity, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, parity, data, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(frame[i]);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    wait_cycles(3);
    vectors++;
    if (code !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: code=%h cv=%b fe=%b, want 00/0/0", code, code_valid, frame_err);
    end
    resetn = 1'b1;
    wait_cycles(5);
    vectors++;
    if (seg_lo !== 7'h40 || seg_hi !== 7'h40) begin
      miscompares++;
      $display("FAIL reset_segments: lo=%h hi=%h, want 40/40", seg_lo, seg_hi);
    end
    vectors++;
    if (cv_total !== 0 || fe_total !== 0 || code !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_quiet: cv=%0d fe=%0d code=%h, want 0/0/00", cv_total, fe_total, code);
    end
  endtask

  task automatic test_parity_err;
    int cv0, fe0;
    cv0 = cv_total; fe0 = fe_total;
    send_bits(8'h1C, 1'b1, 11);
    wait_cycles(10);
    vectors++;
    if (fe_total - fe0 !== 1 || cv_total - cv0 !== 0) begin
      miscompares++;
      $display("FAIL parity_pulses: fe=%0d cv=%0d, want 1/0", fe_total - fe0, cv_total - cv0);
    end
    vectors++;
    if (code !== 8'h00) begin
      miscompares++;
      $display("FAIL parity_code_kept: code=%h, want 00", code);
    end
  endtask

  task automatic test_valid_frame;
    int cv0, fe0;
    cv0 = cv_total; fe0 = fe_total;
    send_bits(8'h1C, 1'b0, 11);
    wait_cycles(10);
    vectors++;
    if (code !== 8'h1C) begin
      miscompares++;
      $display("FAIL valid_code: code=%h, want 1C", code);
    end
    vectors++;
    if (cv_total - cv0 !== 1 || fe_total - fe0 !== 0) begin
      miscompares++;
      $display("FAIL valid_pulses: cv=%0d fe=%0d, want 1/0", cv_total - cv0, fe_total - fe0);
    end
    vectors++;
    if (seg_hi !== 7'h79 || seg_lo !== 7'h46) begin
      miscompares++;
      $display("FAIL valid_segments: hi=%h lo=%h, want 79/46", seg_hi, seg_lo);
    end
  endtask

  task automatic test_back_to_back;
    int cv0, fe0;
    cv0 = cv_total; fe0 = fe_total;
    send_bits(8'hF0, 1'b1, 11);
    vectors++;
    if (code !== 8'hF0) begin
      miscompares++;
      $display("FAIL b2b_first_code: code=%h, want F0", code);
    end
    send_bits(8'h1C, 1'b0, 11);
    wait_cycles(10);
    vectors++;
    if (cv_total - cv0 !== 2 || fe_total - fe0 !== 0 || code !== 8'h1C) begin
      miscompares++;
      $display("FAIL b2b_result: cv=%0d fe=%0d code=%h, want 2/0/1C", cv_total - cv0, fe_total - fe0, code);
    end
    seg_en = 1'b0;
    wait_cycles(1);
    vectors++;
    if (seg_lo !== 7'h7F || seg_hi !== 7'h7F) begin
      miscompares++;
      $display("FAIL blank_segments: lo=%h hi=%h, want 7F/7F", seg_lo, seg_hi);
    end
    seg_en = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_start_high;
    int cv0, fe0;
    cv0 = cv_total; fe0 = fe_total;
    ps2_bit(1'b1);
    wait_cycles(TMO + 20);
    vectors++;
    if (cv_total - cv0 !== 0 || fe_total - fe0 !== 0 || code !== 8'h1C) begin
      miscompares++;
      $display("FAIL start_high_ignored: cv=%0d fe=%0d code=%h, want 0/0/1C", cv_total - cv0, fe_total - fe0, code);
    end
  endtask

  task automatic test_timeout;
    int cv0, fe0;
    cv0 = cv_total; fe0 = fe_total;
    send_bits(8'hA5, 1'b1, 5);
    vectors++;
    if (fe_total - fe0 !== 0) begin
      miscompares++;
      $display("FAIL timeout_early: fe=%0d, want 0", fe_total - fe0);
    end
    wait_cycles(TMO + 60);
    vectors++;
    if (fe_total - fe0 !== 1 || cv_total - cv0 !== 0 || code !== 8'h1C) begin
      miscompares++;
      $display("FAIL timeout_abort: fe=%0d cv=%0d code=%h, want 1/0/1C", fe_total - fe0, cv_total - cv0, code);
    end
    send_bits(8'h32, 1'b0, 11);
    wait_cycles(10);
    vectors++;
    if (code !== 8'h32 || cv_total - cv0 !== 1 || seg_hi !== 7'h30 || seg_lo !== 7'h24) begin
      miscompares++;
      $display("FAIL timeout_recover: code=%h cv=%0d hi=%h lo=%h, want 32/1/30/24", code, cv_total - cv0, seg_hi, seg_lo);
    end
  endtask

  task automatic test_reset_mid_frame;
    int cv0, fe0;
    send_bits(8'h77, 1'b0, 5);
    #3;
    resetn = 1'b0;
    #1;
    vectors++;
    if (code !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0 || seg_lo !== 7'h40 || seg_hi !== 7'h40) begin
      miscompares++;
      $display("FAIL midreset_async: code=%h cv=%b fe=%b lo=%h hi=%h, want 00/0/0/40/40",
               code, code_valid, frame_err, seg_lo, seg_hi);
    end
    wait_cycles(4);
    resetn = 1'b1;
    wait_cycles(5);
    cv0 = cv_total; fe0 = fe_total;
    send_bits(8'h45, 1'b0, 11);
    wait_cycles(10);
    vectors++;
    if (code !== 8'h45 || cv_total - cv0 !== 1 || fe_total - fe0 !== 0) begin
      miscompares++;
      $display("FAIL midreset_next_frame: code=%h cv=%0d fe=%0d, want 45/1/0", code, cv_total - cv0, fe_total - fe0);
    end
    vectors++;
    if (seg_hi !== 7'h19 || seg_lo !== 7'h12) begin
      miscompares++;
      $display("FAIL midreset_segments: hi=%h lo=%h, want 19/12", seg_hi, seg_lo);
    end
  endtask

  task automatic test_exclusive;
    vectors++;
    if (both_total !== 0) begin
      miscompares++;
      $display("FAIL pulse_exclusive: overlapping cycles=%0d, want 0", both_total);
    end
  endtask

  initial begin
    test_reset;
    test_parity_err;
    test_valid_frame;
    test_back_to_back;
    test_start_high;
    test_timeout;
    test_reset_mid_frame;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
